crc_serial_engine: RTL and testbench

//  Single-clock, parametrised serial CRC engine: encodes a data word into a codeword or checks a received codeword.

---
 rtl/crc_pkg.sv | 22 ++
 rtl/crc_serial_engine_if.sv | 29 ++
 rtl/crc_lfsr_step.sv | 16 +
 rtl/crc_serial_engine.sv | 190 +++++++++++++++++++
 tb/tb_crc_serial_engine.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared types and defaults for the serial CRC engine.
package crc_pkg;

  typedef enum logic {
    CRC_ENC = 1'b0,
    CRC_CHK = 1'b1
  } crc_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  localparam int unsigned MSG_W_DEF    = 58;
  localparam int unsigned CRC_W_DEF    = 5;
  localparam int unsigned NUM_POLY_DEF = 2;

  // entry0 = x^5+x^2+1 (LSBs), entry1 = x^5+x^3+x+1
  localparam logic [NUM_POLY_DEF*CRC_W_DEF-1:0] CRC_POLY_TBL_DEF = {5'h0B, 5'h05};

endpackage

// File: rtl/crc_serial_engine_if.sv
// Request/result handshake bundle between upstream, the CRC engine and the output formatter.
interface crc_serial_engine_if #(
  parameter int unsigned MSG_W = 58,
  parameter int unsigned CRC_W = 5,
  parameter int unsigned SEL_W = 1
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [SEL_W-1:0] in_sel;
  logic [MSG_W-1:0] in_msg;
  logic             out_valid;
  logic             out_ready;
  logic [MSG_W-1:0] out_data;
  logic [CRC_W-1:0] out_crc;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_sel, in_msg, out_ready,
    input  in_ready, out_valid, out_data, out_crc, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_sel, in_msg, out_ready,
    output in_ready, out_valid, out_data, out_crc, out_err
  );

endinterface

// File: rtl/crc_lfsr_step.sv
// One MSB-first CRC shift step: feed one data bit into the remainder register.
module crc_lfsr_step #(
  parameter int unsigned CRC_W = 5
) (
  input  logic [CRC_W-1:0] lfsr,
  input  logic             din,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] lfsr_next
);

  logic fb;

  assign fb        = lfsr[CRC_W-1] ^ din;
  assign lfsr_next = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? poly : CRC_W'(0));

endmodule

// File: rtl/crc_serial_engine.sv
// Serial CRC encode/check engine with a 1-deep request buffer and output back-pressure.
// Define CRC_INIT_ONES_EN to preset the remainder register to all ones at load (default: zero).
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned                   MSG_W    = MSG_W_DEF,
  parameter int unsigned                   CRC_W    = CRC_W_DEF,
  parameter int unsigned                   NUM_POLY = NUM_POLY_DEF,
  parameter logic [NUM_POLY*CRC_W-1:0]     POLY_TBL = CRC_POLY_TBL_DEF
) (
  input logic               clk,
  input logic               rst_n,
  crc_serial_engine_if.slave bus
);

  localparam int unsigned D     = MSG_W - CRC_W;
  localparam int unsigned CNT_W = $clog2(D + 1);

`ifdef CRC_INIT_ONES_EN
  localparam logic [CRC_W-1:0] LFSR_INIT = '1;
`else
  localparam logic [CRC_W-1:0] LFSR_INIT = '0;
`endif

  crc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  crc_mode_e        mode_q;
  logic [CRC_W-1:0] poly_q;
  logic [MSG_W-1:0] msg_q;
  logic [D-1:0]     sh_q;
  logic [CRC_W-1:0] lfsr_q;
  logic [CRC_W-1:0] lfsr_next_c;

  logic             pend_full_q, pend_full_d;
  crc_mode_e        pend_mode_q;
  logic [CRC_W-1:0] pend_poly_q;
  logic [MSG_W-1:0] pend_msg_q;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [MSG_W-1:0] out_data_q;
  logic [CRC_W-1:0] out_crc_q;
  logic             out_err_q;

  logic             accept_c, direct_c;
  logic             load_c, load_pend_c, shift_c, capture_c, release_c;
  logic [CRC_W-1:0] in_poly_c;
  crc_mode_e        ld_mode_c;
  logic [CRC_W-1:0] ld_poly_c;
  logic [MSG_W-1:0] ld_msg_c;

  // Out-of-range selects fall back to entry 0; the poly is resolved at accept time.
  always_comb begin
    in_poly_c = POLY_TBL[CRC_W-1:0];
    for (int unsigned k = 0; k < NUM_POLY; k++) begin
      if (32'(bus.in_sel) == k) in_poly_c = POLY_TBL[k*CRC_W +: CRC_W];
    end
  end

  assign accept_c  = bus.in_valid & in_ready_q;
  assign ld_mode_c = load_pend_c ? pend_mode_q : crc_mode_e'(bus.in_mode);
  assign ld_poly_c = load_pend_c ? pend_poly_q : in_poly_c;
  assign ld_msg_c  = load_pend_c ? pend_msg_q  : bus.in_msg;

  crc_lfsr_step #(.CRC_W(CRC_W)) u_step (
    .lfsr      (lfsr_q),
    .din       (sh_q[D-1]),
    .poly      (poly_q),
    .lfsr_next (lfsr_next_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes; an extra SHIFT cycle registers the result.
  always_comb begin
    state_d     = state_q;
    load_c      = 1'b0;
    load_pend_c = 1'b0;
    shift_c     = 1'b0;
    capture_c   = 1'b0;
    release_c   = 1'b0;
    direct_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          load_c      = 1'b1;
          load_pend_c = 1'b1;
          state_d     = SHIFT;
        end else if (accept_c) begin
          load_c   = 1'b1;
          direct_c = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(D)) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end else begin
          shift_c = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          release_c = 1'b1;
          if (pend_full_q) begin
            load_c      = 1'b1;
            load_pend_c = 1'b1;
            state_d     = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pend_full_d = (pend_full_q & ~load_pend_c) | (accept_c & ~direct_c);
  end

  // Pending buffer and accept flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_mode_q <= CRC_ENC;
      pend_poly_q <= '0;
      pend_msg_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      pend_full_q <= pend_full_d;
      in_ready_q  <= ~pend_full_d;
      if (accept_c && !direct_c) begin
        pend_mode_q <= crc_mode_e'(bus.in_mode);
        pend_poly_q <= in_poly_c;
        pend_msg_q  <= bus.in_msg;
      end
    end
  end

  // Working register, remainder, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mode_q      <= CRC_ENC;
      poly_q      <= '0;
      msg_q       <= '0;
      sh_q        <= '0;
      lfsr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_crc_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (load_c) begin
        mode_q <= ld_mode_c;
        poly_q <= ld_poly_c;
        msg_q  <= ld_msg_c;
        sh_q   <= (ld_mode_c == CRC_ENC) ? ld_msg_c[D-1:0] : ld_msg_c[MSG_W-1:CRC_W];
        lfsr_q <= LFSR_INIT;
        cnt_q  <= '0;
      end else if (shift_c) begin
        sh_q   <= {sh_q[D-2:0], 1'b0};
        lfsr_q <= lfsr_next_c;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if (capture_c) begin
        out_valid_q <= 1'b1;
        out_crc_q   <= lfsr_q;
        if (mode_q == CRC_ENC) begin
          out_data_q <= {msg_q[D-1:0], lfsr_q};
          out_err_q  <= 1'b0;
        end else begin
          out_data_q <= msg_q;
          out_err_q  <= (lfsr_q != msg_q[CRC_W-1:0]);
        end
      end else if (release_c) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_crc   = out_crc_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: vector table plus back-pressure, reset and select corner cases.
module tb_crc_serial_engine;
  import crc_pkg::*;

  localparam int unsigned MSG_W = 58;
  localparam int unsigned CRC_W = 5;
  localparam int unsigned D     = MSG_W - CRC_W;
  localparam int unsigned BOUND = 300;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  crc_serial_engine_if #(.MSG_W(MSG_W), .CRC_W(CRC_W), .SEL_W(1)) bus1 ();
  crc_serial_engine_if #(.MSG_W(MSG_W), .CRC_W(CRC_W), .SEL_W(2)) bus3 ();

  crc_serial_engine u_dut (.clk(clk), .rst_n(rst_n), .bus(bus1));

  crc_serial_engine #(
    .NUM_POLY (3),
    .POLY_TBL ({5'h09, 5'h0B, 5'h05})
  ) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             mode;
    logic             sel;
    logic [MSG_W-1:0] msg;
    logic [CRC_W-1:0] crc;
    logic [MSG_W-1:0] data;
    logic             err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic mode, input logic sel, input logic [MSG_W-1:0] msg);
    int n = 0;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_mode  = mode;
    bus1.in_sel   = sel;
    bus1.in_msg   = msg;
    while (!bus1.in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.in_ready) chk("send_timeout", 64'(bus1.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus1.out_valid && lat < BOUND);
    if (!bus1.out_valid) chk({name, "_timeout"}, 64'(bus1.out_valid), 64'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
  endtask

  task automatic chk_result(input string name, input logic [CRC_W-1:0] crc,
                            input logic [MSG_W-1:0] data, input logic err);
    chk({name, "_crc"},  64'(bus1.out_crc),  64'(crc));
    chk({name, "_data"}, 64'(bus1.out_data), 64'(data));
    chk({name, "_err"},  64'(bus1.out_err),  64'(err));
  endtask

  task automatic quiet(input string name, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus1.out_valid) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int               lat;
    logic             ready_seen;
    logic             unstable;
    logic [MSG_W-1:0] hold_data;
    logic [CRC_W-1:0] hold_crc;
    logic             hold_err;
    logic [MSG_W-1:0] enc_word;
    logic [CRC_W-1:0] enc_crc;

    vecs[0] = '{CRC_ENC, 1'b0, 58'd1,                   5'h05, {53'd1, 5'h05}, 1'b0};
    vecs[1] = '{CRC_ENC, 1'b1, 58'd2,                   5'h16, {53'd2, 5'h16}, 1'b0};
    vecs[2] = '{CRC_ENC, 1'b1, 58'd0,                   5'h00, 58'd0,          1'b0};
    vecs[3] = '{CRC_CHK, 1'b0, {53'd1, 5'h05},          5'h05, {53'd1, 5'h05}, 1'b0};
    vecs[4] = '{CRC_CHK, 1'b0, {53'd1, 5'h04},          5'h05, {53'd1, 5'h04}, 1'b1};
    vecs[5] = '{CRC_ENC, 1'b0, 58'd3,                   5'h0F, {53'd3, 5'h0F}, 1'b0};
    vecs[6] = '{CRC_ENC, 1'b0, {5'h1F, 53'd1},          5'h05, {53'd1, 5'h05}, 1'b0};

    rst_n          = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_mode   = 1'b0;
    bus1.in_sel    = '0;
    bus1.in_msg    = '0;
    bus1.out_ready = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.in_mode   = 1'b0;
    bus3.in_sel    = '0;
    bus3.in_msg    = '0;
    bus3.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus1.in_ready),  64'd1);
    chk("rst_out_data",  64'(bus1.out_data),  64'd0);
    chk("rst_out_crc",   64'(bus1.out_crc),   64'd0);
    chk("rst_out_err",   64'(bus1.out_err),   64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef CRC_INIT_ONES_EN
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].mode, vecs[i].sel, vecs[i].msg);
      wait_valid($sformatf("vec%0d", i), lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(D + 1));
      chk_result($sformatf("vec%0d", i), vecs[i].crc, vecs[i].data, vecs[i].err);
      drain();
    end

    // Two back-to-back requests under a stall; a third must wait for a free slot.
    send(CRC_ENC, 1'b0, 58'd1);
    send(CRC_ENC, 1'b1, 58'd2);
    @(negedge clk);
    chk("b2b_in_ready_low", 64'(bus1.in_ready), 64'd0);
    bus1.in_valid = 1'b1;
    bus1.in_mode  = CRC_CHK;
    bus1.in_sel   = 1'b0;
    bus1.in_msg   = {53'd1, 5'h04};
    ready_seen    = 1'b0;
    lat           = 0;
    while (!bus1.out_valid && lat < BOUND) begin
      @(negedge clk);
      lat++;
      if (bus1.in_ready) ready_seen = 1'b1;
    end
    chk("b2b_first_valid", 64'(bus1.out_valid), 64'd1);
    hold_data = bus1.out_data;
    hold_crc  = bus1.out_crc;
    hold_err  = bus1.out_err;
    unstable  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus1.in_ready) ready_seen = 1'b1;
      if (!bus1.out_valid || bus1.out_data !== hold_data ||
          bus1.out_crc !== hold_crc || bus1.out_err !== hold_err) unstable = 1'b1;
    end
    chk("b2b_third_held_off", 64'(ready_seen), 64'd0);
    chk("b2b_stall_stable",   64'(unstable),   64'd0);
    chk_result("b2b_r1", 5'h05, {53'd1, 5'h05}, 1'b0);
    drain();
    @(negedge clk);
    chk("b2b_valid_drop", 64'(bus1.out_valid), 64'd0);
    chk("b2b_ready_free", 64'(bus1.in_ready),  64'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    chk("b2b_third_pending", 64'(bus1.in_ready), 64'd0);
    wait_valid("b2b_r2", lat);
    chk_result("b2b_r2", 5'h16, {53'd2, 5'h16}, 1'b0);
    drain();
    wait_valid("b2b_r3", lat);
    chk_result("b2b_r3", 5'h05, {53'd1, 5'h04}, 1'b1);
    drain();
    quiet("b2b_no_dup", 70);

    // Reset mid-SHIFT with the pending buffer full.
    send(CRC_ENC, 1'b0, 58'd1);
    send(CRC_ENC, 1'b1, 58'd2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus1.in_ready),  64'd1);
    chk("midrst_out_data",  64'(bus1.out_data),  64'd0);
    chk("midrst_out_crc",   64'(bus1.out_crc),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(CRC_ENC, 1'b1, 58'd2);
    wait_valid("post_rst", lat);
    chk("post_rst_latency", 64'(lat), 64'(D + 1));
    chk_result("post_rst", 5'h16, {53'd2, 5'h16}, 1'b0);
    drain();
    quiet("post_rst_no_leftover", 70);

    // Out-of-range select on a three-entry table uses entry 0; entry 2 is distinct.
    for (int s = 3; s >= 2; s--) begin
      @(negedge clk);
      bus3.in_valid = 1'b1;
      bus3.in_mode  = CRC_ENC;
      bus3.in_sel   = 2'(s);
      bus3.in_msg   = 58'd1;
      @(posedge clk);
      #1;
      bus3.in_valid = 1'b0;
      lat = 0;
      while (!bus3.out_valid && lat < BOUND) begin
        @(posedge clk);
        lat++;
        #1;
      end
      chk($sformatf("sel%0d_valid", s), 64'(bus3.out_valid), 64'd1);
      chk($sformatf("sel%0d_crc", s), 64'(bus3.out_crc), (s == 3) ? 64'h05 : 64'h09);
      chk($sformatf("sel%0d_data", s), 64'(bus3.out_data),
          (s == 3) ? 64'({53'd1, 5'h05}) : 64'({53'd1, 5'h09}));
      @(negedge clk);
      bus3.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus3.out_ready = 1'b0;
    end
`endif

    // Encode then check the produced codeword; a flipped data bit must be flagged.
    send(CRC_ENC, 1'b1, 58'h0_1234_5678_9ABC);
    wait_valid("rt_enc", lat);
    chk("rt_enc_latency", 64'(lat), 64'(D + 1));
    chk("rt_enc_data_hi", 64'(bus1.out_data[MSG_W-1:CRC_W]), 64'h0_1234_5678_9ABC);
    enc_word = bus1.out_data;
    enc_crc  = bus1.out_crc;
    chk("rt_enc_err", 64'(bus1.out_err), 64'd0);
    drain();
    send(CRC_CHK, 1'b1, enc_word);
    wait_valid("rt_chk", lat);
    chk_result("rt_chk", enc_crc, enc_word, 1'b0);
    drain();
    enc_word[30] = ~enc_word[30];
    send(CRC_CHK, 1'b1, enc_word);
    wait_valid("rt_bad", lat);
    chk("rt_bad_err",  64'(bus1.out_err),  64'd1);
    chk("rt_bad_data", 64'(bus1.out_data), 64'(enc_word));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
